// File: rtl/spart_mmio_responder.sv
// MMIO register front-end for a SPART UART: DATA/STATUS registers over a
// delayed-ready handshake, backed by RX and TX byte FIFOs.

module spart_mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 wdata_i,
    output logic [W-1:0]                 rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    // Full/empty come from the registered count, so a same-cycle pop never
    // makes room for a push.
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign count_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

module spart_mmio_responder #(
    parameter int FIFO_DEPTH = 8,
    parameter int RESP_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_data1,
    input  logic        mem_rw_data1,
    input  logic [27:0] mem_data_addr1,
    input  logic [31:0] mem_data_wr1,
    output logic [31:0] mem_data_rd1,
    output logic        mem_ready_data1,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam logic [27:0] ADDR_DATA   = 28'h8000000;
    localparam logic [27:0] ADDR_STATUS = 28'h8000001;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [27:0]   addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [7:0]    wbyte_q, wbyte_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          vld_prev_q;
    logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;

    logic          rx_pop, tx_push, sts_clr, tx_ovf_set;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count, tx_count_unused;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic [31:0]   rx_cnt_w, status;
    logic [3:0]    rx_cnt4;
    logic          unused_wr;

    assign unused_wr = ^mem_data_wr1[31:8];

    spart_mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx (
        .clk_i(clk), .rst_ni(rst), .push_i(rx_valid), .pop_i(rx_pop),
        .wdata_i(rx_data), .rdata_o(rx_head), .count_o(rx_count),
        .full_o(rx_full), .empty_o(rx_empty)
    );

    spart_mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx (
        .clk_i(clk), .rst_ni(rst), .push_i(tx_push), .pop_i(tx_valid & tx_ready),
        .wdata_i(wbyte_q), .rdata_o(tx_data), .count_o(tx_count_unused),
        .full_o(tx_full), .empty_o(tx_empty)
    );

    assign tx_valid        = ~tx_empty;
    assign mem_ready_data1 = (state_q == S_RESP);
    assign mem_data_rd1    = rdata_q;

    assign rx_cnt_w = 32'(rx_count);
    assign rx_cnt4  = (rx_cnt_w > 32'd15) ? 4'hF : rx_cnt_w[3:0];
    assign status   = {20'b0, rx_cnt4, 4'b0, tx_ovf_q, rx_ovf_q, ~rx_empty, ~tx_full};

    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wbyte_d    = wbyte_q;
        rdata_d    = rdata_q;
        rx_pop     = 1'b0;
        tx_push    = 1'b0;
        sts_clr    = 1'b0;
        tx_ovf_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Only a fresh rising valid starts a request, so a valid held
                // across reset cannot replay a discarded access.
                if (mem_valid_data1 && !vld_prev_q) begin
                    state_d = S_WAIT;
                    dcnt_d  = '0;
                    addr_d  = mem_data_addr1;
                    rw_d    = mem_rw_data1;
                    wbyte_d = mem_data_wr1[7:0];
                end
            end
            S_WAIT: begin
                if (dcnt_q == DW'(RESP_DELAY - 1)) begin
                    state_d = S_RESP;
                    rdata_d = '0;
                    if (addr_q == ADDR_DATA) begin
                        if (rw_q) begin
                            if (tx_full) tx_ovf_set = 1'b1;
                            else         tx_push    = 1'b1;
                        end else if (!rx_empty) begin
                            rx_pop  = 1'b1;
                            rdata_d = {24'b0, rx_head};
                        end
                    end else if (addr_q == ADDR_STATUS && !rw_q) begin
                        rdata_d = status;
                        sts_clr = 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            S_RESP: begin
                if (!mem_valid_data1) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Sticky flags: a new overflow in the clearing cycle survives.
        rx_ovf_d = (rx_valid & rx_full) | (rx_ovf_q & ~sts_clr);
        tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~sts_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            dcnt_q     <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wbyte_q    <= '0;
            rdata_q    <= '0;
            vld_prev_q <= 1'b1;
            rx_ovf_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wbyte_q    <= wbyte_d;
            rdata_q    <= rdata_d;
            vld_prev_q <= mem_valid_data1;
            rx_ovf_q   <= rx_ovf_d;
            tx_ovf_q   <= tx_ovf_d;
        end
    end
endmodule

// File: tb/tb_spart_mmio_responder.sv
// Bench for spart_mmio_responder: queue-based register model checked every
// cycle, plus directed transactions with hand-computed register values.

module tb_spart_mmio_responder;
    localparam int DEPTH = 8;
    localparam int RD    = 2;
    localparam logic [27:0] A_DATA = 28'h8000000;
    localparam logic [27:0] A_STS  = 28'h8000001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid_data1 = 1'b0, mem_rw_data1 = 1'b0;
    logic [27:0] mem_data_addr1 = '0;
    logic [31:0] mem_data_wr1 = '0;
    logic [31:0] mem_data_rd1;
    logic        mem_ready_data1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    always #5 clk = ~clk;

    spart_mmio_responder #(.FIFO_DEPTH(DEPTH), .RESP_DELAY(RD)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_data1(mem_valid_data1), .mem_rw_data1(mem_rw_data1),
        .mem_data_addr1(mem_data_addr1), .mem_data_wr1(mem_data_wr1),
        .mem_data_rd1(mem_data_rd1), .mem_ready_data1(mem_ready_data1),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Register-level model: byte queues, sticky flags, and a request that
    // completes RESP_DELAY cycles after capture.
    logic [7:0]  m_rxq[$];
    logic [7:0]  m_txq[$];
    bit          m_rx_ovf, m_tx_ovf, m_prev, m_ready, m_rw;
    int          m_phase, m_due, m_cyc;
    logic [31:0] m_rd;
    logic [27:0] m_addr;
    logic [7:0]  m_wb;

    task automatic model_step();
        logic [31:0] sts;
        bit rxf, txf, txpop, clr, txpush, setovf;
        int n;
        if (!rst) begin
            m_rxq.delete(); m_txq.delete();
            m_rx_ovf = 0; m_tx_ovf = 0; m_prev = 1; m_ready = 0;
            m_phase = 0; m_rd = '0; m_cyc = 0;
            return;
        end
        m_cyc++;
        n = (m_rxq.size() > 15) ? 15 : m_rxq.size();
        sts = {20'b0, 4'(n), 4'b0, m_tx_ovf, m_rx_ovf,
               m_rxq.size() > 0, m_txq.size() < DEPTH};
        rxf = m_rxq.size() >= DEPTH;
        txf = m_txq.size() >= DEPTH;
        txpop = (m_txq.size() > 0) && tx_ready;
        clr = 0; txpush = 0; setovf = 0;
        if (m_phase == 0) begin
            if (mem_valid_data1 && !m_prev) begin
                m_phase = 1; m_due = m_cyc + RD;
                m_addr = mem_data_addr1; m_rw = mem_rw_data1; m_wb = mem_data_wr1[7:0];
            end
        end else if (m_phase == 1) begin
            if (m_cyc == m_due) begin
                m_phase = 2; m_ready = 1; m_rd = '0;
                if (m_addr == A_DATA && m_rw) begin
                    if (txf) setovf = 1; else txpush = 1;
                end else if (m_addr == A_DATA) begin
                    if (m_rxq.size() > 0) m_rd = {24'b0, m_rxq.pop_front()};
                end else if (m_addr == A_STS && !m_rw) begin
                    m_rd = sts; clr = 1;
                end
            end
        end else if (!mem_valid_data1) begin
            m_phase = 0; m_ready = 0; m_rd = '0;
        end
        if (clr) begin m_rx_ovf = 0; m_tx_ovf = 0; end
        if (txpop) void'(m_txq.pop_front());
        if (txpush) m_txq.push_back(m_wb);
        if (setovf) m_tx_ovf = 1;
        if (rx_valid) begin
            if (rxf) m_rx_ovf = 1; else m_rxq.push_back(rx_data);
        end
        m_prev = mem_valid_data1;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("cyc_ready", {31'b0, mem_ready_data1}, {31'b0, m_ready});
            chk("cyc_rdata", mem_data_rd1, m_rd);
            chk("cyc_tx_valid", {31'b0, tx_valid}, {31'b0, m_txq.size() > 0});
            chk("cyc_tx_data", {24'b0, tx_data}, {24'b0, (m_txq.size() > 0) ? m_txq[0] : 8'h00});
        end
    end

    task automatic push_rx(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // One access; valid stays high for `hold` ready cycles before dropping.
    task automatic mmio(input bit rw, input logic [27:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output int lat);
        @(negedge clk);
        mem_valid_data1 = 1'b1; mem_rw_data1 = rw; mem_data_addr1 = a; mem_data_wr1 = wd;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!mem_ready_data1 && lat < 50);
        rd = mem_data_rd1;
        if (!mem_ready_data1) chk("ready_timeout", 32'(lat), 32'(RD + 1));
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk("ready_hold", {31'b0, mem_ready_data1}, 32'd1);
            chk("rdata_hold", mem_data_rd1, rd);
        end
        mem_valid_data1 = 1'b0;
        @(negedge clk);
        chk("ready_drop", {31'b0, mem_ready_data1}, 32'd0);
        chk("rdata_drop", mem_data_rd1, 32'd0);
    endtask

    logic [31:0] rd;
    int lat;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, mem_ready_data1}, 32'd0);
        chk("rst_rdata", mem_data_rd1, 32'd0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        mmio(0, A_STS, 0, 1, rd, lat);
        chk("sts_after_reset", rd, 32'h00000001);
        chk("latency", 32'(lat), 32'(RD + 1));

        push_rx(8'hA5); push_rx(8'h3C);
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_rx2", rd, 32'h00000203);
        mmio(0, A_DATA, 0, 1, rd, lat); chk("rx_read1", rd, 32'h000000A5);
        mmio(0, A_DATA, 0, 1, rd, lat); chk("rx_read2", rd, 32'h0000003C);
        mmio(0, A_DATA, 0, 1, rd, lat); chk("rx_read_empty", rd, 32'h00000000);
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_rx_empty", rd, 32'h00000001);

        mmio(1, A_DATA, 32'h12345678, 1, rd, lat);
        chk("tx_valid_wr", {31'b0, tx_valid}, 32'd1);
        chk("tx_data_wr", {24'b0, tx_data}, 32'h78);
        @(negedge clk); tx_ready = 1'b1;
        @(negedge clk); tx_ready = 1'b0;
        chk("tx_valid_popped", {31'b0, tx_valid}, 32'd0);

        for (int i = 0; i < 9; i++) mmio(1, A_DATA, 32'hA0 + 32'(i), 1, rd, lat);
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_tx_ovf", rd, 32'h00000008);
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_tx_ovf_clr", rd, 32'h00000000);
        chk("tx_head_first", {24'b0, tx_data}, 32'hA0);
        @(negedge clk); tx_ready = 1'b1;
        repeat (8) @(negedge clk);
        tx_ready = 1'b0;
        chk("tx_drained", {31'b0, tx_valid}, 32'd0);

        for (int i = 0; i < 9; i++) push_rx(8'h10 + 8'(i));
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_rx_ovf", rd, 32'h00000807);
        mmio(0, A_DATA, 0, 5, rd, lat); chk("rx_hold5", rd, 32'h00000010);
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_single_pop", rd, 32'h00000703);

        mmio(1, 28'h0000123, 32'h000000FF, 1, rd, lat);
        mmio(0, 28'h0000123, 0, 1, rd, lat); chk("unmapped_rd", rd, 32'h0);
        mmio(1, A_STS, 32'hFFFFFFFF, 1, rd, lat);
        chk("unmapped_no_tx", {31'b0, tx_valid}, 32'd0);
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_unchanged", rd, 32'h00000703);

        for (int i = 1; i < 7; i++) begin
            mmio(0, A_DATA, 0, 1, rd, lat); chk("rx_drain", rd, 32'h10 + 32'(i));
        end

        // Reset mid-WAIT of a DATA read with one RX byte queued.
        @(negedge clk);
        mem_valid_data1 = 1'b1; mem_rw_data1 = 1'b0; mem_data_addr1 = A_DATA;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, mem_ready_data1}, 32'd0);
        chk("midrst_rdata", mem_data_rd1, 32'd0);
        @(negedge clk); mem_valid_data1 = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", {31'b0, mem_ready_data1}, 32'd0);
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_post_rst", rd, 32'h00000001);

        // Overflow set coinciding with a STATUS clear keeps the flag.
        for (int i = 0; i < 8; i++) push_rx(8'h40 + 8'(i));
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'hEE;
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_set_clr1", rd, 32'h00000807);
        rx_valid = 1'b0;
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_set_wins", rd, 32'h00000807);
        mmio(0, A_STS, 0, 1, rd, lat); chk("sts_cleared", rd, 32'h00000803);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spart_mmio_responder.md
SPART_MMIO_RESPONDER -- requirements
Module: spart_mmio_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, RX and TX FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RESP_DELAY, default 2, cycles from request capture to mem_ready_data1 assertion (>=1).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port mem_valid_data1, input, 1 bit, initiator request valid.
REQ-006 SHALL have port mem_rw_data1, input, 1 bit, 1=write, 0=read.
REQ-007 SHALL have port mem_data_addr1, input, 28 bits, register address.
REQ-008 SHALL have port mem_data_wr1, input, 32 bits, write data.
REQ-009 SHALL have port mem_data_rd1, output, 32 bits, read data.
REQ-010 SHALL have port mem_ready_data1, output, 1 bit, response handshake.
REQ-011 SHALL have port rx_data, input, 8 bits, received byte from SPART receiver.
REQ-012 SHALL have port rx_valid, input, 1 bit, one-cycle push strobe for rx_data.
REQ-013 SHALL have port tx_data, output, 8 bits, TX FIFO head byte.
REQ-014 SHALL have port tx_valid, output, 1 bit, TX FIFO not empty.
REQ-015 SHALL have port tx_ready, input, 1 bit, transmitter accepts tx_data.

Function
REQ-016 SHALL map addresses: 28'h8000000 DATA, 28'h8000001 STATUS; all others UNMAPPED.
REQ-017 SHALL run FSM IDLE -> WAIT -> RESP -> IDLE; IDLE->WAIT when mem_valid_data1=1, capturing addr, rw, wr data.
REQ-018 SHALL count RESP_DELAY cycles in WAIT, then enter RESP with mem_ready_data1=1 and mem_data_rd1 valid.
REQ-019 SHALL hold mem_ready_data1=1 and mem_data_rd1 stable in RESP until mem_valid_data1=0, then return to IDLE with ready=0 and mem_data_rd1=0 the next cycle.
REQ-020 SHALL perform side effects (pop, push, sticky clear) exactly once, on the WAIT->RESP transition.
REQ-021 SHALL return STATUS = {20'b0, rx_count[3:0], 4'b0, tx_ovf, rx_ovf, rx_nonempty, tx_nonfull}; rx_count saturates at 15.
REQ-022 SHALL clear rx_ovf and tx_ovf on a STATUS read; STATUS write is ignored.
REQ-023 SHALL on DATA read return {24'b0, RX head} and pop; if RX empty return 0, no pop.
REQ-024 SHALL on DATA write push mem_data_wr1[7:0] into TX; if TX full, drop byte and set tx_ovf.
REQ-025 SHALL acknowledge UNMAPPED accesses normally, reads return 32'h0, writes no effect.
REQ-026 SHALL push rx_data when rx_valid=1 and RX not full; if full, drop byte, set rx_ovf (pop in same cycle does not make room).
REQ-027 SHALL pop TX when tx_valid=1 and tx_ready=1; tx_data = TX head, 0 when empty.
REQ-028 SHALL keep pointers FIFO_DEPTH-wrapping with count 0..FIFO_DEPTH; simultaneous push and pop on non-full, non-empty FIFO leaves count unchanged.
REQ-029 SHALL set sticky bit if set and clear coincide in same cycle (set wins).

Reset
REQ-030 SHALL on rst=0 immediately force FSM IDLE, mem_ready_data1=0, mem_data_rd1=0, tx_valid=0, tx_data=0, both FIFOs empty, rx_ovf=tx_ovf=0.
REQ-031 SHALL discard any in-flight request on reset mid-transaction; no side effect after reset release until a new mem_valid_data1 rising.

Verification
REQ-032 SHALL verify STATUS read after reset -> mem_data_rd1=32'h00000001, ready exactly RESP_DELAY+1 cycles after valid.
REQ-033 SHALL verify rx_valid with bytes 8'hA5,8'h3C, then DATA reads -> 32'h000000A5 then 32'h0000003C; third read -> 0, STATUS bit1=0.
REQ-034 SHALL verify DATA write 32'h12345678 -> tx_valid=1, tx_data=8'h78; tx_ready=1 one cycle -> tx_valid=0.
REQ-035 SHALL verify 9 DATA writes with tx_ready=0 (depth 8) -> 9th dropped, STATUS=32'h00000008; next STATUS read bit3=0.
REQ-036 SHALL verify valid held 5 cycles into RESP -> ready held 5 cycles, single RX pop only.
REQ-037 SHALL verify rst=0 asserted during WAIT of DATA read with RX=1 byte -> ready=0, rx_count=0 after reset.
